// File: rtl/sram_req_arbiter.sv
// Two-to-one SRAM-port arbiter (inst fetch vs load/store) with an in-order owner FIFO.
// Define ARB_ROUND_ROBIN_EN to alternate grants under contention instead of fixed data priority.
module sram_req_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);

  logic                   lock_r;
  logic                   lock_id_r;
  logic [OUTSTANDING-1:0] owner_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [PW-1:0]          wr_ptr_r;
  logic [CW-1:0]          count_r;

  logic grant_s;
  logic sel_req_s;
  logic full_s;
  logic push_s;
  logic pop_s;
  logic head_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_id_r;
`endif

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    if (ptr == PW'(OUTSTANDING - 1)) begin
      return PW'(0);
    end else begin
      return ptr + PW'(1);
    end
  endfunction

  // Grant selection: a held address phase keeps its owner until accepted.
  always_comb begin
    grant_s = 1'b0;
    if (lock_r) begin
      grant_s = lock_id_r;
    end else begin
`ifdef ARB_ROUND_ROBIN_EN
      if (inst_req && data_req) begin
        grant_s = ~last_id_r;
      end else begin
        grant_s = data_req;
      end
`else
      grant_s = data_req;
`endif
    end
  end

  assign full_s    = (count_r == CW'(OUTSTANDING));
  assign sel_req_s = grant_s ? data_req : inst_req;
  assign push_s    = mem_req && mem_addr_ok;
  assign pop_s     = mem_data_ok && (count_r != CW'(0)) && !reset;
  assign head_s    = owner_r[rd_ptr_r];

  assign mem_req   = sel_req_s && !full_s && !reset;
  assign mem_wr    = grant_s ? data_wr    : inst_wr;
  assign mem_size  = grant_s ? data_size  : inst_size;
  assign mem_wstrb = grant_s ? data_wstrb : inst_wstrb;
  assign mem_addr  = grant_s ? data_addr  : inst_addr;
  assign mem_wdata = grant_s ? data_wdata : inst_wdata;

  assign inst_addr_ok = push_s && !grant_s;
  assign data_addr_ok = push_s && grant_s;
  assign inst_data_ok = pop_s && !head_s;
  assign data_data_ok = pop_s && head_s;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Lock FSM: hold the grant while an issued request waits for mem_addr_ok.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_r    <= 1'b0;
      lock_id_r <= 1'b0;
    end else if (!lock_r) begin
      if (mem_req && !mem_addr_ok) begin
        lock_r    <= 1'b1;
        lock_id_r <= grant_s;
      end
    end else if (mem_addr_ok) begin
      lock_r <= 1'b0;
    end
  end

  // Owner FIFO: records who issued each accepted request so responses route back in order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_r  <= '0;
      rd_ptr_r <= PW'(0);
      wr_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_s) begin
        owner_r[wr_ptr_r] <= grant_s;
        wr_ptr_r          <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember the last accepted side so contention alternates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_id_r <= 1'b1;
    end else if (push_s) begin
      last_id_r <= grant_s;
    end
  end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter with a queue-based reference model checked every cycle.
module tb_sram_req_arbiter;
  localparam int OUTSTANDING = 2;

  logic        clk;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  sram_req_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, who is waiting, and who each in-flight response belongs to.
  bit owners[$];
  bit held;
  bit held_id;
  bit last_side;

  always @(negedge clk) begin
    bit g, want, full, ereq, accept, resp, head;
    if (reset) begin
      owners.delete();
      held = 1'b0;
      last_side = 1'b1;
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
      chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    end else begin
      if (held) g = held_id;
`ifdef ARB_ROUND_ROBIN_EN
      else if (inst_req && data_req) g = !last_side;
`endif
      else g = data_req;
      want   = g ? data_req : inst_req;
      full   = (owners.size() == OUTSTANDING);
      ereq   = want && !full;
      accept = ereq && mem_addr_ok;
      resp   = mem_data_ok && (owners.size() > 0);
      head   = resp ? owners[0] : 1'b0;
      chk("mem_req", {31'd0, mem_req}, {31'd0, ereq});
      chk("mem_addr", mem_addr, g ? data_addr : inst_addr);
      chk("mem_wdata", mem_wdata, g ? data_wdata : inst_wdata);
      chk("mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb},
          g ? {25'd0, data_wr, data_size, data_wstrb} : {25'd0, inst_wr, inst_size, inst_wstrb});
      chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, accept && !g});
      chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, accept && g});
      chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, resp && !head});
      chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, resp && head});
      chk("rdata", inst_rdata ^ data_rdata, 32'd0);
      chk("inst_rdata", inst_rdata, mem_rdata);
      if (resp) void'(owners.pop_front());
      if (accept) begin
        owners.push_back(g);
        last_side = g;
      end
      if (!held && ereq && !mem_addr_ok) begin
        held = 1'b1;
        held_id = g;
      end else if (held && mem_addr_ok) begin
        held = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hF; inst_wdata = 32'h1111_1111;
    data_wr = 1'b1; data_size = 2'd1; data_wstrb = 4'h3; data_wdata = 32'h2222_2222;
    inst_addr = 32'h1C00_0000; data_addr = 32'h0000_1000; mem_rdata = 32'h0;
    idle();
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("reset_hold_mem_req", {31'd0, mem_req}, 32'd0);
    step(); reset = 1'b0; idle();
    step();

    // Contention: data wins, inst follows next cycle.
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("cont_addr", mem_addr, 32'h0000_1000);
    chk("cont_data_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("cont_inst_ok", {31'd0, inst_addr_ok}, 32'd0);
    step(); data_req = 1'b0;
    @(negedge clk);
    chk("cont_addr2", mem_addr, 32'h1C00_0000);
    step(); idle(); mem_data_ok = 1'b1; mem_rdata = 32'h0000_00D1;
    @(negedge clk);
    chk("cont_ret_data", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
    step(); mem_rdata = 32'h0000_001E;
    @(negedge clk);
    chk("cont_ret_inst", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
    step(); idle();

    // Lock: inst held for three stalled cycles while data arrives.
    inst_addr = 32'h0000_0100; data_addr = 32'h0000_0200;
    inst_req = 1'b1;
    @(negedge clk); chk("lock_c1", mem_addr, 32'h0000_0100);
    step(); data_req = 1'b1;
    @(negedge clk); chk("lock_c2", mem_addr, 32'h0000_0100);
    step();
    @(negedge clk); chk("lock_c3", mem_addr, 32'h0000_0100);
    step(); mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("lock_c4_inst_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("lock_c4_data_ok", {31'd0, data_addr_ok}, 32'd0);
    step(); inst_req = 1'b0; mem_addr_ok = 1'b0;
    @(negedge clk); chk("unlock_to_data", mem_addr, 32'h0000_0200);
    step(); mem_addr_ok = 1'b1;
    @(negedge clk); chk("data_accept", {31'd0, data_addr_ok}, 32'd1);

    // Ordering: inst then data outstanding.
    step(); idle(); mem_data_ok = 1'b1; mem_rdata = 32'hAAAA_0000;
    @(negedge clk);
    chk("ord1_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
    chk("ord1_rdata", inst_rdata, 32'hAAAA_0000);
    step(); mem_rdata = 32'h5555_FFFF;
    @(negedge clk);
    chk("ord2_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
    chk("ord2_rdata", data_rdata, 32'h5555_FFFF);

    // Full: two accepts, then data_req blocked until a response has been popped.
    step(); idle(); inst_req = 1'b1; mem_addr_ok = 1'b1;
    step(); inst_req = 1'b0; data_req = 1'b1;
    step();
    @(negedge clk);
    chk("full_req", {31'd0, mem_req}, 32'd0);
    chk("full_no_ok", {31'd0, data_addr_ok}, 32'd0);
    step(); mem_data_ok = 1'b1; mem_rdata = 32'h0000_0042;
    @(negedge clk);
    chk("full_pop_req", {31'd0, mem_req}, 32'd0);
    chk("full_pop_inst", {31'd0, inst_data_ok}, 32'd1);
    step(); mem_data_ok = 1'b0;
    @(negedge clk);
    chk("after_full_req", {31'd0, mem_req}, 32'd1);
    step(); idle(); mem_data_ok = 1'b1;
    step(); step();
    // FIFO now empty: a stray response must be ignored.
    @(negedge clk);
    chk("empty_resp", {30'd0, inst_data_ok, data_data_ok}, 32'd0);

    // Reset mid-transaction with two outstanding.
    step(); idle(); inst_req = 1'b1; mem_addr_ok = 1'b1;
    step(); inst_req = 1'b0; data_req = 1'b1;
    step(); idle(); inst_req = 1'b1; mem_data_ok = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("rst_mid_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    step(); reset = 1'b0; idle(); mem_data_ok = 1'b1;
    @(negedge clk);
    chk("post_rst_resp", {30'd0, inst_data_ok, data_data_ok}, 32'd0);

`ifdef ARB_ROUND_ROBIN_EN
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_grant", {30'd0, inst_addr_ok, data_addr_ok}, (i % 2 == 0) ? 32'd2 : 32'd1);
      step();
    end
`endif

    step(); idle(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Two-to-one arbiter that shares a single SRAM-like memory port between the instruction-fetch requester and the load/store requester of the pipeline. It sits between the IF/MEM stages and the memory bridge. It selects one requester per address phase and holds that grant until the address is accepted. It tracks outstanding transactions in an in-order owner FIFO so each `data_ok`/`rdata` returns to the requester that issued it.

## Interface
- `OUTSTANDING`, default 2: maximum accepted-but-not-returned transactions; 1..4.
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `inst_req` / `data_req`  in  1  requester address-phase request.
- `inst_wr` / `data_wr`  in  1  1 = write.
- `inst_size` / `data_size`  in  2  0 = byte, 1 = half, 2 = word.
- `inst_wstrb` / `data_wstrb`  in  4  byte strobes.
- `inst_addr` / `data_addr`  in  32  address.
- `inst_wdata` / `data_wdata`  in  32  write data.
- `inst_addr_ok` / `data_addr_ok`  out  1  address accepted this cycle.
- `inst_data_ok` / `data_data_ok`  out  1  response valid this cycle.
- `inst_rdata` / `data_rdata`  out  32  read data, valid with `*_data_ok`.
- `mem_req`, `mem_wr`, `mem_size[1:0]`, `mem_wstrb[3:0]`, `mem_addr[31:0]`, `mem_wdata[31:0]`  out  downstream request, muxed from the granted requester.
- `mem_addr_ok`  in  1  downstream accepted the request.
- `mem_data_ok`  in  1  downstream response valid.
- `mem_rdata`  in  32  downstream read data.

## Operation
- State: `lock` (1b), `lock_id` (1b; 0 = inst, 1 = data), owner FIFO of `OUTSTANDING` 1-bit entries with rd/wr pointers and a count.
- `full` = (count == `OUTSTANDING`), taken from the registered count only. A same-cycle pop does not free a slot for a push.
- Grant selection when `lock`=0: data wins if `data_req`, else inst. When `lock`=1, grant = `lock_id`, regardless of the request lines.
- `mem_req` = granted requester's req && !`full`. All `mem_*` request fields come from the granted requester. When `mem_req`=0 the fields are don't-care but driven from the granted side.
- `*_addr_ok` = `mem_addr_ok` && `mem_req` && (grant == that side). Never asserted for both sides in one cycle.
- Lock FSM:
  - UNLOCKED → LOCKED when `mem_req` && !`mem_addr_ok`; `lock_id` is set to the grant.
  - LOCKED → UNLOCKED on `mem_addr_ok`.
  - A requester must not drop `req` while locked.
- Push the granted id on `mem_req` && `mem_addr_ok`. Pop the head on `mem_data_ok` when count > 0.
- `inst_data_ok` = `mem_data_ok` && count>0 && head==0. `data_data_ok` = same with head==1. Both `*_rdata` = `mem_rdata`, unconditionally.
- `mem_data_ok` with an empty FIFO is ignored: no `*_data_ok`, state unchanged.
- Pointers wrap modulo `OUTSTANDING`. Count stays within 0..`OUTSTANDING`. Simultaneous push and pop leaves count unchanged.
- Reset (async, any time, including mid-transaction):
  - `lock`=0, count=0, pointers=0.
  - All `*_addr_ok`, `*_data_ok` and `mem_req` = 0.
  - In-flight responses are discarded.

## Timing
- Zero-cycle request path: a request to `mem_req` and `mem_addr_ok` to `*_addr_ok` are combinational in the same cycle.
- Zero-cycle response path: `mem_data_ok` to `*_data_ok` in the same cycle.
- Minimum address-to-response latency is set downstream. The arbiter adds none.
- Back-to-back accepts every cycle are sustained while !`full`.
- Responses return strictly in issue order.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - Adds a 1-bit `last_id` register, reset to 1 (data).
  - When `lock`=0 and both requests are high, grant goes to the side ≠ `last_id`.
  - `last_id` updates on every accepted push.
- Undefined: fixed data-over-inst priority as described in Operation.

## Test plan
- **Reset:** assert `reset` mid-cycle with count=2 → all outputs 0 immediately. After release, `mem_data_ok` alone produces no `*_data_ok`.
- **Contention:** `inst_req`=`data_req`=1 at 0x1C000000 / 0x00001000, `mem_addr_ok`=1 → `mem_addr`=0x00001000, `data_addr_ok`=1, `inst_addr_ok`=0. Next cycle `mem_addr`=0x1C000000.
- **Lock:**
  - `inst_req`=1, `mem_addr_ok`=0 for 3 cycles, `data_req` rises in cycle 2 → `mem_addr` stays on inst.
  - Cycle 4 `mem_addr_ok`=1 → `inst_addr_ok`=1, lock clears.
- **Ordering:**
  - Accept inst then data with OUTSTANDING=2, then return `mem_rdata`=0xAAAA0000 followed by 0x5555FFFF.
  - → `inst_data_ok` with 0xAAAA0000, then `data_data_ok` with 0x5555FFFF.
- **Full:**
  - Two accepts with no response → `mem_req`=0 despite `data_req`=1.
  - A cycle with `mem_data_ok`=1 still has `mem_req`=0.
  - The next cycle `mem_req`=1.
- **Round-robin (with `ARB_ROUND_ROBIN_EN`):** both sides requesting continuously, `mem_addr_ok`=1 every cycle and responses draining → grants alternate inst, data, inst, data from reset.
